// File: rtl/display_pkg.sv
// Shared constants and state encodings for the UART-fed 7-segment display path.
package display_pkg;

    localparam int         NUM_DIGITS     = 16;
    localparam logic [7:0] DEF_SYNC_BYTE  = 8'hA5;
    localparam logic [7:0] DEF_INIT_CMD   = 8'h89;
    localparam logic [7:0] DEF_INIT_POS   = 8'hFF;
    localparam logic [3:0] DEF_POS_PREFIX = 4'hC;

    typedef enum logic [1:0] {OUT_IDLE, OUT_INIT, OUT_PAUSE, OUT_SEND} out_state_t;
    typedef enum logic       {COL_WAIT_SYNC, COL_COLLECT}               col_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP}      rx_state_t;

endpackage

// File: rtl/uart_display_loader_if.sv
// Command handshake toward the serial display writer.
interface uart_display_loader_if;

    logic       valid;
    logic [7:0] pos;
    logic [7:0] value;
    logic       busy;

    modport master (output valid, pos, value, input busy);
    modport slave  (input valid, pos, value, output busy);

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-FF synchroniser plus bit-centre sampler.
module uart_rx_byte
    import display_pkg::*;
#(
    parameter int CLK_HZ = 12_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX,
    output logic [7:0] rx_byte,
    output logic       rx_stb,
    output logic       rx_ferr
);

    localparam int            DIV       = CLK_HZ / BAUD;
    localparam int            CW        = $clog2(DIV + 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

    logic          rx_meta, rx_sync, rx_prev;
    rx_state_t     state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic [7:0]    shreg, shreg_next;
    logic          stb_next, ferr_next;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            rx_stb  <= 1'b0;
            rx_ferr <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            shreg   <= shreg_next;
            rx_stb  <= stb_next;
            rx_ferr <= ferr_next;
        end
    end

    // Returns to idle right after the stop-bit sample so back-to-back bytes are not missed.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt + 1'b1;
        bit_idx_next = bit_idx;
        shreg_next   = shreg;
        stb_next     = 1'b0;
        ferr_next    = 1'b0;
        unique case (state)
            RX_IDLE: begin
                cnt_next = '0;
                if (rx_prev && !rx_sync) state_next = RX_START;
            end
            RX_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_next     = '0;
                    shreg_next   = {rx_sync, shreg[7:1]};
                    bit_idx_next = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == FULL_LAST) begin
                    state_next = RX_IDLE;
                    stb_next   = rx_sync;
                    ferr_next  = !rx_sync;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    assign rx_byte = shreg;

endmodule

// File: rtl/uart_display_loader.sv
// Collects 16-byte frames from the host UART and replays them to the display writer.
module uart_display_loader
    import display_pkg::*;
#(
    parameter int         CLK_HZ         = 12_000_000,
    parameter int         BAUD           = 115_200,
    parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
    parameter logic [7:0] INIT_CMD       = DEF_INIT_CMD,
    parameter logic [7:0] INIT_POS       = DEF_INIT_POS,
    parameter logic [3:0] POS_PREFIX     = DEF_POS_PREFIX,
    parameter int         PAUSE_CYCLES   = CLK_HZ / 1000,
    parameter int         TIMEOUT_CYCLES = 10 * CLK_HZ / 1000
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         RX,
    uart_display_loader_if.master        cmd,
    output logic                         frame_done,
    output logic                         err
);

    localparam int            PW           = $clog2(PAUSE_CYCLES + 1);
    localparam int            TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW-1:0] PAUSE_LAST   = PW'(PAUSE_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    LAST_DIGIT   = 4'(NUM_DIGITS - 1);

    logic [7:0] rx_byte;
    logic       rx_stb, rx_ferr;

    uart_rx_byte #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
        .CLK     (CLK),
        .RST     (RST),
        .RX      (RX),
        .rx_byte (rx_byte),
        .rx_stb  (rx_stb),
        .rx_ferr (rx_ferr)
    );

    col_state_t    col_state, col_state_next;
    logic [3:0]    idx, idx_next;
    logic [TW-1:0] to_cnt, to_cnt_next;
    logic          frame_rdy, frame_rdy_next, sbuf_we, timeout;
    logic [7:0]    sbuf [NUM_DIGITS];
    logic [7:0]    obuf [NUM_DIGITS];

    out_state_t    out_state, out_state_next;
    logic [3:0]    n, n_next;
    logic [PW-1:0] pause_cnt, pause_cnt_next;
    logic          valid_q, valid_next, done_next, obuf_load, overrun;
    logic [7:0]    pos_q, pos_next, value_q, value_next;

    always_ff @(posedge CLK) begin
        if (RST) begin
            col_state <= COL_WAIT_SYNC;
            idx       <= '0;
            to_cnt    <= '0;
            frame_rdy <= 1'b0;
        end else begin
            col_state <= col_state_next;
            idx       <= idx_next;
            to_cnt    <= to_cnt_next;
            frame_rdy <= frame_rdy_next;
        end
    end

    // Inside a frame every byte is payload, including one that looks like the sync marker.
    always_comb begin
        col_state_next = col_state;
        idx_next       = idx;
        to_cnt_next    = to_cnt + 1'b1;
        frame_rdy_next = 1'b0;
        sbuf_we        = 1'b0;
        timeout        = 1'b0;
        unique case (col_state)
            COL_WAIT_SYNC: begin
                to_cnt_next = '0;
                if (rx_stb && rx_byte == SYNC_BYTE) begin
                    col_state_next = COL_COLLECT;
                    idx_next       = '0;
                end
            end
            COL_COLLECT: begin
                if (rx_stb) begin
                    sbuf_we     = 1'b1;
                    to_cnt_next = '0;
                    idx_next    = idx + 1'b1;
                    if (idx == LAST_DIGIT) begin
                        col_state_next = COL_WAIT_SYNC;
                        frame_rdy_next = 1'b1;
                    end
                end else if (to_cnt == TIMEOUT_LAST) begin
                    timeout        = 1'b1;
                    col_state_next = COL_WAIT_SYNC;
                end
            end
            default: col_state_next = COL_WAIT_SYNC;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (sbuf_we) sbuf[idx] <= rx_byte;
        if (obuf_load) obuf <= sbuf;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_state  <= OUT_IDLE;
            n          <= '0;
            pause_cnt  <= '0;
            valid_q    <= 1'b0;
            pos_q      <= '0;
            value_q    <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            out_state  <= out_state_next;
            n          <= n_next;
            pause_cnt  <= pause_cnt_next;
            valid_q    <= valid_next;
            pos_q      <= pos_next;
            value_q    <= value_next;
            frame_done <= done_next;
            err        <= err | rx_ferr | timeout | overrun;
        end
    end

    // Gating on valid_q keeps strobes at least two cycles apart even if busy lags.
    always_comb begin
        out_state_next = out_state;
        n_next         = n;
        pause_cnt_next = pause_cnt;
        valid_next     = 1'b0;
        done_next      = 1'b0;
        pos_next       = pos_q;
        value_next     = value_q;
        obuf_load      = 1'b0;
        overrun        = frame_rdy && (out_state != OUT_IDLE);
        unique case (out_state)
            OUT_IDLE: begin
                if (frame_rdy) begin
                    obuf_load      = 1'b1;
                    out_state_next = OUT_INIT;
                end
            end
            OUT_INIT: begin
                if (!cmd.busy && !valid_q) begin
                    pos_next       = INIT_POS;
                    value_next     = INIT_CMD;
                    valid_next     = 1'b1;
                    pause_cnt_next = '0;
                    out_state_next = OUT_PAUSE;
                end
            end
            OUT_PAUSE: begin
                if (pause_cnt == PAUSE_LAST) begin
                    n_next         = '0;
                    out_state_next = OUT_SEND;
                end else begin
                    pause_cnt_next = pause_cnt + 1'b1;
                end
            end
            OUT_SEND: begin
                if (!cmd.busy && !valid_q) begin
                    pos_next   = {POS_PREFIX, n};
                    value_next = obuf[n];
                    valid_next = 1'b1;
                    n_next     = n + 1'b1;
                    if (n == LAST_DIGIT) begin
                        done_next      = 1'b1;
                        out_state_next = OUT_IDLE;
                    end
                end
            end
            default: out_state_next = OUT_IDLE;
        endcase
    end

    assign cmd.valid = valid_q;
    assign cmd.pos   = pos_q;
    assign cmd.value = value_q;

endmodule

// File: tb/tb_uart_display_loader.sv
// Directed bench for uart_display_loader with a scoreboard of expected display commands.
module tb_uart_display_loader;

    localparam int         TB_CLK_HZ  = 1_152_000;
    localparam int         TB_BAUD    = 115_200;
    localparam int         DIV        = TB_CLK_HZ / TB_BAUD;
    localparam int         PAUSE      = 200;
    localparam int         TIMEOUT    = 600;
    localparam logic [7:0] SYNC       = 8'hA5;
    localparam logic [7:0] INIT_CMD   = 8'h89;
    localparam logic [7:0] INIT_POS   = 8'hFF;
    localparam logic [3:0] POS_PREFIX = 4'hC;

    typedef struct packed {
        logic [7:0] pos;
        logic [7:0] value;
        logic       done;
    } cmd_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic RX  = 1'b1;
    logic frame_done, err;

    uart_display_loader_if cmd_if ();

    uart_display_loader #(
        .CLK_HZ         (TB_CLK_HZ),
        .BAUD           (TB_BAUD),
        .SYNC_BYTE      (SYNC),
        .INIT_CMD       (INIT_CMD),
        .INIT_POS       (INIT_POS),
        .POS_PREFIX     (POS_PREFIX),
        .PAUSE_CYCLES   (PAUSE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX         (RX),
        .cmd        (cmd_if),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 CLK = ~CLK;

    int         tests_run  = 0;
    int         fail_count = 0;
    int         busy_hold  = 3;
    cmd_t       sb [$];
    logic [7:0] frame_data [16];

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stop_bit);
        @(negedge CLK);
        RX = 1'b0;
        repeat (DIV) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (DIV) @(negedge CLK);
        end
        RX = stop_bit;
        repeat (DIV) @(negedge CLK);
        RX = 1'b1;
        repeat (DIV) @(negedge CLK);
    endtask

    task automatic pushExpected(input int digits);
        sb.push_back('{pos: INIT_POS, value: INIT_CMD, done: 1'b0});
        for (int i = 0; i < digits; i++)
            sb.push_back('{pos: {POS_PREFIX, 4'(i)}, value: frame_data[i], done: (i == 15)});
    endtask

    task automatic applyStimulus(input bit expect_replay);
        if (expect_replay) pushExpected(16);
        sendByte(SYNC, 1'b1);
        for (int i = 0; i < 16; i++) sendByte(frame_data[i], 1'b1);
    endtask

    task automatic waitDrain(input int budget);
        for (int c = 0; c < budget && sb.size() > 0; c++) begin
            @(negedge CLK);
            #2;
        end
        checkOutput("scoreboard drained", 8'(sb.size()), 8'd0);
    endtask

    task automatic resetDut();
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        sb.delete();
    endtask

    // Writer model: raises busy straight after seeing a strobe and holds it busy_hold cycles.
    initial begin
        cmd_if.busy = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (cmd_if.valid === 1'b1) begin
                cmd_if.busy = 1'b1;
                repeat (busy_hold) @(posedge CLK);
                #1 cmd_if.busy = 1'b0;
            end
        end
    end

    // Every strobe must match the head of the scoreboard and never follow another strobe.
    initial begin
        logic prev_valid = 1'b0;
        forever begin
            @(negedge CLK);
            if (cmd_if.valid === 1'b1) begin
                checkOutput("valid spacing", 8'(prev_valid), 8'd0);
                checkOutput("valid expected", 8'(sb.size() > 0), 8'd1);
                if (sb.size() > 0) begin
                    cmd_t e;
                    e = sb.pop_front();
                    checkOutput("pos", cmd_if.pos, e.pos);
                    checkOutput("value", cmd_if.value, e.value);
                    checkOutput("frame_done", 8'(frame_done), 8'(e.done));
                end
            end
            prev_valid = cmd_if.valid;
        end
    end

    initial begin
        #(60000 * 10);
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (4) @(negedge CLK);
        RST = 1'b0;
        checkOutput("reset valid", 8'(cmd_if.valid), 8'd0);
        checkOutput("reset pos", cmd_if.pos, 8'h00);
        checkOutput("reset value", cmd_if.value, 8'h00);
        checkOutput("reset frame_done", 8'(frame_done), 8'd0);
        checkOutput("reset err", 8'(err), 8'd0);

        // Full frame 00..0F
        for (int i = 0; i < 16; i++) frame_data[i] = 8'(i);
        applyStimulus(1'b1);
        waitDrain(2000);
        checkOutput("full frame err", 8'(err), 8'd0);

        // Junk before sync is ignored
        for (int i = 0; i < 16; i++) frame_data[i] = 8'(8'h30 + i * 7);
        sendByte(8'h12, 1'b1);
        sendByte(8'h34, 1'b1);
        applyStimulus(1'b1);
        waitDrain(2000);
        checkOutput("junk err", 8'(err), 8'd0);

        // Timeout on a partial frame, then a frame carrying the sync value as data
        sendByte(SYNC, 1'b1);
        for (int i = 0; i < 5; i++) sendByte(8'(8'h50 + i), 1'b1);
        checkOutput("pre-timeout err", 8'(err), 8'd0);
        repeat (TIMEOUT + 100) @(negedge CLK);
        checkOutput("timeout err", 8'(err), 8'd1);
        for (int i = 0; i < 16; i++) frame_data[i] = 8'(8'hE0 - i * 3);
        frame_data[4] = SYNC;
        applyStimulus(1'b1);
        waitDrain(2000);
        checkOutput("sticky err", 8'(err), 8'd1);

        // Framing error inside a frame drops that byte only
        resetDut();
        checkOutput("err cleared by reset", 8'(err), 8'd0);
        for (int i = 0; i < 16; i++) frame_data[i] = 8'(8'h81 + i * 11);
        pushExpected(16);
        sendByte(SYNC, 1'b1);
        for (int i = 0; i < 3; i++) sendByte(frame_data[i], 1'b1);
        sendByte(8'hEE, 1'b0);
        for (int i = 3; i < 16; i++) sendByte(frame_data[i], 1'b1);
        waitDrain(2000);
        checkOutput("framing err", 8'(err), 8'd1);

        // Overrun under heavy backpressure: second frame arrives mid-replay
        resetDut();
        busy_hold = 500;
        for (int i = 0; i < 16; i++) frame_data[i] = 8'(8'h10 + i * 5);
        applyStimulus(1'b1);
        checkOutput("pre-overrun err", 8'(err), 8'd0);
        for (int i = 0; i < 16; i++) frame_data[i] = 8'(8'hC3 ^ i);
        applyStimulus(1'b0);
        waitDrain(12000);
        repeat (600) @(negedge CLK);
        checkOutput("overrun err", 8'(err), 8'd1);
        busy_hold = 3;

        // Reset right after digit 7 is issued
        resetDut();
        for (int i = 0; i < 16; i++) frame_data[i] = 8'(8'h99 - i);
        pushExpected(8);
        applyStimulus(1'b0);
        waitDrain(2000);
        RST = 1'b1;
        @(negedge CLK);
        checkOutput("mid-replay reset valid", 8'(cmd_if.valid), 8'd0);
        checkOutput("mid-replay reset pos", cmd_if.pos, 8'h00);
        checkOutput("mid-replay reset value", cmd_if.value, 8'h00);
        checkOutput("mid-replay reset frame_done", 8'(frame_done), 8'd0);
        checkOutput("mid-replay reset err", 8'(err), 8'd0);
        RST = 1'b0;
        repeat (400) @(negedge CLK);
        checkOutput("no strobes after reset", 8'(sb.size()), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
